// File: rtl/absdiff_frame_ctrl_if.sv
// FIFO-side bundle for absdiff_frame_ctrl: x/y first-word-fall-through read ports and the z write port.
interface absdiff_frame_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  // Handshake: a read happens on the rising edge where rd_en=1, and rd_en is only
  // driven high while the matching empty flag is 0. A write happens on the rising
  // edge where wr_en=1, and wr_en is only driven high while full is 0.
  logic [DATA_WIDTH-1:0] x_dout;
  logic                  x_empty;
  logic                  x_rd_en;
  logic [DATA_WIDTH-1:0] y_dout;
  logic                  y_empty;
  logic                  y_rd_en;
  logic [DATA_WIDTH-1:0] z_din;
  logic                  z_full;
  logic                  z_wr_en;

  modport master (
    input  x_dout, x_empty, y_dout, y_empty, z_full,
    output x_rd_en, y_rd_en, z_din, z_wr_en
  );

  modport slave (
    output x_dout, x_empty, y_dout, y_empty, z_full,
    input  x_rd_en, y_rd_en, z_din, z_wr_en
  );
endinterface

// File: rtl/absdiff_frame_ctrl.sv
// Frame sequencer: reads frame_len x/y pairs, writes MARK_VALUE or 0 per |x-y| > threshold.
// Optional hit counter output enabled by defining ABSDIFF_HITCNT_EN.
module absdiff_frame_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    LEN_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] MARK_VALUE = 'hFF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  input  logic [DATA_WIDTH-1:0] threshold,
  output logic                  busy,
  output logic                  done,
`ifdef ABSDIFF_HITCNT_EN
  output logic [LEN_WIDTH-1:0]  hit_count,
`endif
  output logic [1:0]            dbg_state,
  absdiff_frame_ctrl_if.master  fifo
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, cnt_q, cnt_next;
  logic [DATA_WIDTH-1:0] thr_q, diff_q, diff_d;
  logic                  start_acc, pair_ok, rd_fire, wr_fire, mark;

  assign start_acc = (state_q == S_IDLE) && start;
  assign pair_ok   = !fifo.x_empty && !fifo.y_empty;
  assign rd_fire   = (state_q == S_READ) && pair_ok;
  assign wr_fire   = (state_q == S_WRITE) && !fifo.z_full;
  assign cnt_next  = cnt_q + 1'b1;
  assign mark      = diff_q > thr_q;
  assign dbg_state = state_q;

  // Larger minus smaller, so the unsigned result never wraps.
  assign diff_d = (fifo.y_dout > fifo.x_dout) ? (fifo.y_dout - fifo.x_dout)
                                              : (fifo.x_dout - fifo.y_dout);

  always_comb begin
    state_d      = state_q;
    busy         = 1'b0;
    done         = 1'b0;
    fifo.x_rd_en = 1'b0;
    fifo.y_rd_en = 1'b0;
    fifo.z_wr_en = 1'b0;
    fifo.z_din   = '0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (frame_len == '0) ? S_DONE : S_READ;
      end
      S_READ: begin
        busy = 1'b1;
        if (pair_ok) begin
          fifo.x_rd_en = 1'b1;
          fifo.y_rd_en = 1'b1;
          state_d      = S_WRITE;
        end
      end
      S_WRITE: begin
        busy = 1'b1;
        if (!fifo.z_full) begin
          fifo.z_wr_en = 1'b1;
          fifo.z_din   = mark ? MARK_VALUE : '0;
          state_d      = (cnt_next == len_q) ? S_DONE : S_READ;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      thr_q   <= '0;
      cnt_q   <= '0;
      diff_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        len_q <= frame_len;
        thr_q <= threshold;
        cnt_q <= '0;
      end
      if (rd_fire) diff_q <= diff_d;
      if (wr_fire) cnt_q  <= cnt_next;
    end
  end

`ifdef ABSDIFF_HITCNT_EN
  logic [LEN_WIDTH-1:0] hit_q;

  // Saturates so a long frame of marks never wraps back to a small count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_q <= '0;
    end else if (start_acc) begin
      hit_q <= '0;
    end else if (wr_fire && mark && (hit_q != '1)) begin
      hit_q <= hit_q + 1'b1;
    end
  end

  assign hit_count = hit_q;
`else
  // Without the hit counter there is no extra state to maintain.
`endif

endmodule

// File: tb/tb_absdiff_frame_ctrl.sv
// Self-checking bench for absdiff_frame_ctrl: queue-modelled FIFOs, scoreboarded z writes.
module tb_absdiff_frame_ctrl;
  localparam int DW = 32;
  localparam int LW = 16;
  localparam logic [DW-1:0] MARK = 32'hFF;

  typedef struct {
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [DW-1:0] thr;
    logic [DW-1:0] z;
  } vec_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] frame_len = '0;
  logic [DW-1:0] threshold = '0;
  logic          busy, done;
  logic [1:0]    dbg_state;
`ifdef ABSDIFF_HITCNT_EN
  logic [LW-1:0] hit_count;
`endif

  absdiff_frame_ctrl_if #(.DATA_WIDTH(DW)) fifo_if ();

  absdiff_frame_ctrl #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .MARK_VALUE(MARK)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .frame_len (frame_len),
    .threshold (threshold),
    .busy      (busy),
    .done      (done),
`ifdef ABSDIFF_HITCNT_EN
    .hit_count (hit_count),
`endif
    .dbg_state (dbg_state),
    .fifo      (fifo_if)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  // scoreboard and FIFO models
  logic [DW-1:0] x_q[$], y_q[$], exp_q[$];
  int   n_vec = 0, n_err = 0;
  int   cyc = 0, n_reads = 0, n_writes = 0, done_cnt = 0, busy_cnt = 0, last_done_cyc = -1;
  logic prev_done = 1'b0;
  int   y_blk_lo = -1, y_blk_hi = -1, z_blk_lo = -1, z_blk_hi = -1;
  vec_t tbl1[4];
  vec_t tbl_edge[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_z(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                            input logic [DW-1:0] thr);
    logic [DW-1:0] d;
    if (x >= y) d = x - y;
    else        d = y - x;
    return (d > thr) ? MARK : '0;
  endfunction

  task automatic push_pair(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [DW-1:0] z);
    x_q.push_back(x);
    y_q.push_back(y);
    exp_q.push_back(z);
  endtask

  // One cycle: drive FIFO flags, sample outputs mid-cycle, then cross the rising edge.
  task automatic step();
    logic [DW-1:0] act_z;
    logic [DW-1:0] want_z;
    fifo_if.x_empty = (x_q.size() == 0);
    fifo_if.x_dout  = (x_q.size() != 0) ? x_q[0] : '0;
    fifo_if.y_empty = (y_q.size() == 0) || (cyc >= y_blk_lo && cyc < y_blk_hi);
    fifo_if.y_dout  = (y_q.size() != 0) ? y_q[0] : '0;
    fifo_if.z_full  = (cyc >= z_blk_lo && cyc < z_blk_hi);
    #1;
    if (fifo_if.x_rd_en || fifo_if.y_rd_en) begin
      chk("rd_pair", fifo_if.x_rd_en, fifo_if.y_rd_en);
      chk("rd_when_empty", fifo_if.x_empty || fifo_if.y_empty, 1'b0);
      if (fifo_if.x_rd_en && x_q.size() != 0) void'(x_q.pop_front());
      if (fifo_if.y_rd_en && y_q.size() != 0) void'(y_q.pop_front());
      n_reads++;
    end
    if (fifo_if.z_wr_en) begin
      chk("wr_when_full", fifo_if.z_full, 1'b0);
      act_z = fifo_if.z_din;
      if (exp_q.size() == 0) begin
        chk("z_unexpected_write", 1'b1, 1'b0);
      end else begin
        want_z = exp_q.pop_front();
        chk("z_din", act_z, want_z);
      end
      n_writes++;
    end else if (fifo_if.z_din !== '0) begin
      chk("z_din_idle", fifo_if.z_din, '0);
    end
    if (done) begin
      if (prev_done) chk("done_width", 1'b1, 1'b0);
      done_cnt++;
      last_done_cyc = cyc;
    end
    prev_done = done;
    if (busy) busy_cnt++;
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input int dc0, output int d);
    for (int i = 0; i < 300 && done_cnt == dc0; i++) step();
    if (done_cnt == dc0) begin
      chk("frame_timeout", 1'b0, 1'b1);
      d = -1;
    end else begin
      d = last_done_cyc;
    end
  endtask

  task automatic run_frame(input logic [LW-1:0] len, input logic [DW-1:0] thr,
                           output int s, output int d);
    int dc0;
    dc0       = done_cnt;
    frame_len = len;
    threshold = thr;
    start     = 1'b1;
    s         = cyc;
    step();
    start     = 1'b0;
    wait_done(dc0, d);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_rd"}, {fifo_if.x_rd_en, fifo_if.y_rd_en}, 2'b00);
    chk({tag, "_wr"}, fifo_if.z_wr_en, 1'b0);
    chk({tag, "_zdin"}, fifo_if.z_din, '0);
    chk({tag, "_state"}, dbg_state, 2'd0);
  endtask

  initial begin
    int s, d, w0, r0, b0, dc0;
    logic [DW-1:0] xv, yv, tv;

    tbl1[0] = '{x: 32'd100, y: 32'd40,  thr: 32'd50, z: 32'hFF};
    tbl1[1] = '{x: 32'd40,  y: 32'd100, thr: 32'd50, z: 32'hFF};
    tbl1[2] = '{x: 32'd10,  y: 32'd60,  thr: 32'd50, z: 32'h0};
    tbl1[3] = '{x: 32'd60,  y: 32'd60,  thr: 32'd50, z: 32'h0};
    tbl_edge[0] = '{x: 32'h0,        y: 32'hFFFFFFFF, thr: 32'hFFFFFFFE, z: 32'hFF};
    tbl_edge[1] = '{x: 32'h0,        y: 32'hFFFFFFFF, thr: 32'hFFFFFFFF, z: 32'h0};
    tbl_edge[2] = '{x: 32'hFFFFFFFF, y: 32'h0,        thr: 32'hFFFFFFFE, z: 32'hFF};
    tbl_edge[3] = '{x: 32'h5,        y: 32'h5,        thr: 32'h0,        z: 32'h0};

    // reset state
    step();
    step();
    check_idle_outputs("reset");
`ifdef ABSDIFF_HITCNT_EN
    chk("reset_hit", hit_count, '0);
`endif
    reset = 1'b1;
    step();

    // basic frame from the table
    for (int i = 0; i < 4; i++) push_pair(tbl1[i].x, tbl1[i].y, tbl1[i].z);
    w0 = n_writes; b0 = busy_cnt;
    run_frame(16'd4, 32'd50, s, d);
    chk("f1_done_lat", d - s, 9);
    chk("f1_writes", n_writes - w0, 4);
    chk("f1_busy_cycles", busy_cnt - b0, 8);
`ifdef ABSDIFF_HITCNT_EN
    chk("f1_hit", hit_count, 16'd2);
    step(); step();
    chk("f1_hit_hold", hit_count, 16'd2);
`endif

    // y empty for 5 cycles after start, z full 3 cycles at 2nd write
    push_pair(32'd5, 32'd200, model_z(32'd5, 32'd200, 32'd100));
    push_pair(32'd300, 32'd1, model_z(32'd300, 32'd1, 32'd100));
    push_pair(32'd7, 32'd9, model_z(32'd7, 32'd9, 32'd100));
    w0 = n_writes;
    y_blk_lo = cyc + 1; y_blk_hi = cyc + 6;
    z_blk_lo = cyc + 9; z_blk_hi = cyc + 12;
    run_frame(16'd3, 32'd100, s, d);
    y_blk_lo = -1; y_blk_hi = -1; z_blk_lo = -1; z_blk_hi = -1;
    chk("f2_done_lat", d - s, 15);
    chk("f2_writes", n_writes - w0, 3);

    // zero-length frame: FIFOs hold data but must not be touched
    x_q.push_back(32'd1);
    y_q.push_back(32'd2);
    w0 = n_writes; r0 = n_reads; b0 = busy_cnt;
    run_frame(16'd0, 32'd0, s, d);
    chk("f0_done_lat", d - s, 1);
    chk("f0_reads", n_reads - r0, 0);
    chk("f0_writes", n_writes - w0, 0);
    chk("f0_busy", busy_cnt - b0, 0);
`ifdef ABSDIFF_HITCNT_EN
    chk("f0_hit_clear", hit_count, '0);
`endif
    x_q.delete();
    y_q.delete();

    // second start and threshold change mid-frame are ignored
    for (int i = 0; i < 3; i++) push_pair(32'd100, 32'd130, model_z(32'd100, 32'd130, 32'd50));
    w0 = n_writes; dc0 = done_cnt;
    frame_len = 16'd3; threshold = 32'd50; start = 1'b1;
    s = cyc;
    step();
    start = 1'b0;
    step(); step();
    start = 1'b1; frame_len = 16'd5; threshold = 32'd0;
    step();
    start = 1'b0;
    wait_done(dc0, d);
    chk("f4_done_lat", d - s, 7);
    chk("f4_writes", n_writes - w0, 3);
    b0 = busy_cnt; dc0 = done_cnt;
    for (int i = 0; i < 4; i++) step();
    chk("f4_no_requeue_busy", busy_cnt - b0, 0);
    chk("f4_no_requeue_done", done_cnt - dc0, 0);

    // reset mid-frame after 2 of 5 elements
    for (int i = 0; i < 5; i++) begin
      xv = DW'($urandom_range(0, 1000));
      yv = DW'($urandom_range(0, 1000));
      push_pair(xv, yv, model_z(xv, yv, 32'd200));
    end
    w0 = n_writes; dc0 = done_cnt;
    frame_len = 16'd5; threshold = 32'd200; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 60 && (n_writes - w0) < 2; i++) step();
    chk("f5_two_writes", n_writes - w0, 2);
    reset = 1'b0;
    #1;
    check_idle_outputs("midreset");
`ifdef ABSDIFF_HITCNT_EN
    chk("midreset_hit", hit_count, '0);
`endif
    step(); step();
    reset = 1'b1;
    chk("f5_no_done", done_cnt - dc0, 0);
    chk("f5_fifo_untouched", x_q.size(), 3);
    x_q.delete(); y_q.delete(); exp_q.delete();
    push_pair(32'd9, 32'd500, model_z(32'd9, 32'd500, 32'd100));
    w0 = n_writes;
    run_frame(16'd1, 32'd100, s, d);
    chk("f5_after_lat", d - s, 3);
    chk("f5_after_writes", n_writes - w0, 1);

    // boundary magnitudes, one single-element frame per row
    for (int i = 0; i < 4; i++) begin
      push_pair(tbl_edge[i].x, tbl_edge[i].y, tbl_edge[i].z);
      run_frame(16'd1, tbl_edge[i].thr, s, d);
      chk("edge_lat", d - s, 3);
    end

    // random frame against the model
    tv = DW'($urandom_range(0, 500));
    for (int i = 0; i < 6; i++) begin
      xv = DW'($urandom_range(0, 1000));
      yv = DW'($urandom_range(0, 1000));
      push_pair(xv, yv, model_z(xv, yv, tv));
    end
    w0 = n_writes;
    run_frame(16'd6, tv, s, d);
    chk("rand_done_lat", d - s, 13);
    chk("rand_writes", n_writes - w0, 6);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
